// File: rtl/multicycle_control_unit.sv
// Moore-FSM sequencer for the multicycle MIPS datapath: fetch/decode/execute/
// memory/writeback over several clocks, with memory-ready stalls and a mul wait.
module multicycle_control_unit #(
   parameter int ALUC_W     = 3,
   parameter int MUL_CYCLES = 4,
   parameter int CNT_W      = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [5:0]        opcode,
   input  logic [5:0]        funct,
   input  logic              zero,
   input  logic              mem_ready,
   output logic              iord,
   output logic              mem_write,
   output logic              ir_write,
   output logic              reg_dst,
   output logic              mem_to_reg,
   output logic              reg_write,
   output logic              alu_src_a,
   output logic [1:0]        alu_src_b,
   output logic [ALUC_W-1:0] alu_control,
   output logic [1:0]        pc_src,
   output logic              pc_en,
   output logic              busy_mul,
   output logic              illegal_op,
   output logic [3:0]        state_o
);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECUTE  = 4'd6,
      ALUWB    = 4'd7,
      BRANCH   = 4'd8,
      ADDIEXEC = 4'd9,
      ADDIWB   = 4'd10,
      JUMP     = 4'd11,
      MULWAIT  = 4'd12
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] F_ADD = 6'b100000;
   localparam logic [5:0] F_SUB = 6'b100010;
   localparam logic [5:0] F_SLT = 6'b101010;
   localparam logic [5:0] F_MUL = 6'b011100;

   localparam logic [ALUC_W-1:0] ALU_ADD = ALUC_W'(3'b010);
   localparam logic [ALUC_W-1:0] ALU_SUB = ALUC_W'(3'b100);
   localparam logic [ALUC_W-1:0] ALU_SLT = ALUC_W'(3'b110);
   localparam logic [ALUC_W-1:0] ALU_MUL = ALUC_W'(3'b101);

   // Counter is loaded with MUL_CYCLES-1 so MULWAIT lasts exactly MUL_CYCLES cycles.
   localparam logic [CNT_W-1:0] MUL_LOAD = (MUL_CYCLES > 0) ? CNT_W'(MUL_CYCLES - 1) : '0;

   state_t           state_q, state_d, disp_state;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pc_write, branch;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= FETCH;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = FETCH;
      cnt_d   = cnt_q;
      case (state_q)
         FETCH:    state_d = mem_ready ? DECODE : FETCH;
         DECODE: begin
            case (opcode)
               OP_LW, OP_SW: state_d = MEMADR;
               OP_RTYPE:     state_d = EXECUTE;
               OP_BEQ:       state_d = BRANCH;
               OP_ADDI:      state_d = ADDIEXEC;
               OP_J:         state_d = JUMP;
               default:      state_d = FETCH;
            endcase
         end
         MEMADR:   state_d = (opcode == OP_LW) ? MEMREAD : MEMWRITE;
         MEMREAD:  state_d = mem_ready ? MEMWB : MEMREAD;
         MEMWRITE: state_d = mem_ready ? FETCH : MEMWRITE;
         EXECUTE: begin
            if ((funct == F_MUL) && (MUL_CYCLES > 0)) begin
               cnt_d   = MUL_LOAD;
               state_d = MULWAIT;
            end else begin
               state_d = ALUWB;
            end
         end
         MULWAIT: begin
            if (cnt_q == '0) begin
               state_d = ALUWB;
            end else begin
               cnt_d   = cnt_q - CNT_W'(1);
               state_d = MULWAIT;
            end
         end
         ADDIEXEC: state_d = ADDIWB;
         default:  state_d = FETCH;
      endcase
   end

   // While reset is held the outputs show FETCH values with every strobe suppressed.
   always_comb begin
      disp_state  = rst ? FETCH : state_q;
      iord        = 1'b0;
      mem_write   = 1'b0;
      ir_write    = 1'b0;
      reg_dst     = 1'b0;
      mem_to_reg  = 1'b0;
      reg_write   = 1'b0;
      alu_src_a   = 1'b0;
      alu_src_b   = 2'b00;
      alu_control = ALU_ADD;
      pc_src      = 2'b00;
      busy_mul    = 1'b0;
      illegal_op  = 1'b0;
      pc_write    = 1'b0;
      branch      = 1'b0;
      case (disp_state)
         FETCH: begin
            alu_src_b = 2'b01;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
         end
         DECODE: begin
            alu_src_b  = 2'b11;
            illegal_op = !(opcode inside {OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J});
         end
         MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
         end
         MEMREAD:  iord = 1'b1;
         MEMWB: begin
            mem_to_reg = 1'b1;
            reg_write  = 1'b1;
         end
         MEMWRITE: begin
            iord      = 1'b1;
            mem_write = 1'b1;
         end
         EXECUTE: begin
            alu_src_a = 1'b1;
            case (funct)
               F_SUB:   alu_control = ALU_SUB;
               F_SLT:   alu_control = ALU_SLT;
               F_MUL:   alu_control = ALU_MUL;
               F_ADD:   alu_control = ALU_ADD;
               default: alu_control = ALU_ADD;
            endcase
         end
         MULWAIT: begin
            alu_src_a   = 1'b1;
            alu_control = ALU_MUL;
            busy_mul    = 1'b1;
         end
         ALUWB: begin
            reg_dst   = 1'b1;
            reg_write = 1'b1;
         end
         BRANCH: begin
            alu_src_a   = 1'b1;
            alu_control = ALU_SUB;
            branch      = 1'b1;
            pc_src      = 2'b01;
         end
         ADDIEXEC: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
         end
         ADDIWB:   reg_write = 1'b1;
         JUMP: begin
            pc_src   = 2'b10;
            pc_write = 1'b1;
         end
         default: ;
      endcase
      pc_en = pc_write | (branch & zero);
      if (rst) begin
         mem_write  = 1'b0;
         ir_write   = 1'b0;
         reg_write  = 1'b0;
         pc_en      = 1'b0;
         illegal_op = 1'b0;
         busy_mul   = 1'b0;
      end
      state_o = disp_state;
   end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
Moore-FSM control unit for the multicycle MIPS datapath, the sequential successor to the single-cycle main/ALU decoder. It sequences fetch/decode/execute/memory/writeback over several clocks and shares one ALU and one memory port. It adds a memory-ready handshake and a parametrised multi-cycle `mul` wait. It sits between the instruction register (opcode/funct), the ALU zero flag, the unified memory and the datapath muxes/enables.

Parameters:
ALUC_W, 3, width of alu_control (codes occupy the low 3 bits, upper bits zero)
MUL_CYCLES, 4, extra cycles spent in MULWAIT for `mul` (0 = no wait state, EXECUTE goes straight to ALUWB)
CNT_W, 4, width of the mul wait counter (must hold MUL_CYCLES-1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
opcode  in  6  instr[31:26] from instruction register
funct  in  6  instr[5:0] from instruction register
zero  in  1  ALU zero flag
mem_ready  in  1  memory access completes this cycle
iord  out  1  memory address select: 0 = PC, 1 = ALUOut
mem_write  out  1  memory write strobe
ir_write  out  1  instruction register load
reg_dst  out  1  write register: 0 = rt, 1 = rd
mem_to_reg  out  1  writeback data: 0 = ALUOut, 1 = Data
reg_write  out  1  register file write
alu_src_a  out  1  0 = PC, 1 = A
alu_src_b  out  2  00 = B, 01 = const 4, 10 = SignImm, 11 = SignImm<<2
alu_control  out  ALUC_W  010 add, 100 sub, 110 slt, 101 mul
pc_src  out  2  00 = ALUResult, 01 = ALUOut, 10 = jump target
pc_en  out  1  PC load = pc_write | (branch & zero)
busy_mul  out  1  high in MULWAIT
illegal_op  out  1  one-cycle pulse on unrecognised opcode in DECODE
state_o  out  4  current state encoding, for debug

Behaviour:
- Clock/reset: one clock, clk; reset rst is synchronous and active-high. rst high at a rising edge -> state = FETCH and mul counter = 0. While rst is high, all strobes (mem_write, ir_write, reg_write, pc_en, illegal_op, busy_mul) are forced 0. All other outputs hold their FETCH values.
- Default for every output is 0, alu_control = add. States list only the non-default values.
- State encodings 0..12: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTE, ALUWB, BRANCH, ADDIEXEC, ADDIWB, JUMP, MULWAIT.
- FETCH: alu_src_b = 01, add.
  - ir_write and pc_write are asserted only while mem_ready = 1, then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: alu_src_b = 11, add. Next state by opcode:
  - 100011 or 101011 -> MEMADR
  - 000000 -> EXECUTE
  - 000100 -> BRANCH
  - 001000 -> ADDIEXEC
  - 000010 -> JUMP
  - any other -> FETCH, with illegal_op = 1 this cycle.
- MEMADR: alu_src_a = 1, alu_src_b = 10, add. lw -> MEMREAD; sw -> MEMWRITE.
- MEMREAD: iord = 1. Stay until mem_ready, then go to MEMWB.
- MEMWB: mem_to_reg = 1, reg_write = 1 -> FETCH.
- MEMWRITE: iord = 1, mem_write = 1, held until mem_ready, then go to FETCH.
- EXECUTE: alu_src_a = 1, alu_src_b = 00. alu_control decodes funct:
  - 100000 add, 100010 sub, 101010 slt, 011100 mul; other values -> add.
  - If funct = mul and MUL_CYCLES > 0: load counter with MUL_CYCLES-1 and go to MULWAIT.
  - Otherwise go to ALUWB.
- MULWAIT: same datapath controls as EXECUTE with mul, busy_mul = 1. Counter decrements each cycle; go to ALUWB when it is 0. Exactly MUL_CYCLES cycles are spent here.
- ALUWB: reg_dst = 1, reg_write = 1 -> FETCH.
- BRANCH: alu_src_a = 1, sub, branch = 1, pc_src = 01 -> FETCH. pc_en = zero.
- ADDIEXEC: alu_src_a = 1, alu_src_b = 10, add -> ADDIWB.
- ADDIWB: reg_write = 1 -> FETCH.
- JUMP: pc_src = 10, pc_write = 1 -> FETCH.
- Latency with mem_ready held at 1: lw 5, sw 4, R-type 4, mul 4+MUL_CYCLES, beq 3, addi 4, j 3 cycles.
- Each mem_ready = 0 cycle in FETCH, MEMREAD or MEMWRITE adds one cycle.
- opcode and funct are used only in DECODE, EXECUTE and MEMADR. The IR is stable in those states.
- Unused state codes (13..15) -> FETCH on the next edge.

Test Plan:
- rst high 2 cycles, then low with mem_ready = 1 and `add` (opcode 0, funct 100000) -> states 0,1,6,7,0. In state 7: reg_write = 1, reg_dst = 1, alu_control = 010. ir_write and pc_en = 1 only in the FETCH cycle.
- lw, mem_ready low 2 cycles in FETCH and 3 cycles in MEMREAD -> 10 total cycles. ir_write pulses exactly once. MEMWB has mem_to_reg = 1, reg_write = 1.
- mul (funct 011100), MUL_CYCLES = 4 -> busy_mul high 4 cycles, alu_control = 101 throughout, 8 cycles total. With MUL_CYCLES = 0 -> 4 cycles, busy_mul never set.
- beq with zero = 1 -> BRANCH cycle has pc_en = 1, pc_src = 01, alu_control = 100. Repeat with zero = 0 -> pc_en = 0.
- opcode 111111 -> illegal_op one-cycle pulse in DECODE, return to FETCH, no reg_write or mem_write.
- rst asserted during MULWAIT (counter = 2) -> next edge state_o = 0, busy_mul = 0. After release, a fresh fetch proceeds normally.
